// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg : MIPS opcode constants and fetch FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  function automatic logic is_jump_op(input logic [5:0] opcode);
    return (opcode == OP_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_fetch_next_pc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_next_pc : static not-taken next-PC, resolving J targets in fetch
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_next_pc
  import instruction_fetch_unit_pkg::*;
(
  input  logic [29:0] i_pc,
  input  logic [31:0] i_instruction,
  output logic [29:0] o_next_pc,
  output logic        o_is_jump
);

  logic [29:0] w_pc_plus1;

  // Word-address increment wraps naturally at 2^30
  assign w_pc_plus1 = i_pc + 30'd1;
  assign o_is_jump  = is_jump_op(i_instruction[31:26]);

  always_comb begin
    o_next_pc = w_pc_plus1;
    if (o_is_jump) begin
      o_next_pc = {w_pc_plus1[29:26], i_instruction[25:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_unit : single-stage fetch from combinational ROM
// Revision: 1.0
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_target,
  output logic [29:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [29:0] if_pc,
  output logic        if_is_jump,
  output logic [15:0] bubble_count
);

  logic [1:0]  r_state;
  logic [29:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instruction;
  logic [29:0] r_if_pc;
  logic        r_if_is_jump;
  logic [15:0] r_bubble_count;

  logic [29:0] w_next_pc;
  logic        w_is_jump;
  logic        w_if_valid_nxt;

  fetch_next_pc u_fetch_next_pc (
    .i_pc          (r_pc),
    .i_instruction (imem_instruction),
    .o_next_pc     (w_next_pc),
    .o_is_jump     (w_is_jump)
  );

  // A stalled cycle keeps whatever validity the output register already had
  always_comb begin
    w_if_valid_nxt = 1'b1;
    if (redirect_valid || (r_state == ST_BOOT)) begin
      w_if_valid_nxt = 1'b0;
    end else if (stall) begin
      w_if_valid_nxt = r_if_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_BOOT;
      r_pc             <= RESET_PC;
      r_if_valid       <= 1'b0;
      r_if_instruction <= 32'h0;
      r_if_pc          <= 30'h0;
      r_if_is_jump     <= 1'b0;
      r_bubble_count   <= 16'h0;
    end else begin
      r_if_valid <= w_if_valid_nxt;
      if (!w_if_valid_nxt && (r_bubble_count != 16'hFFFF)) begin
        r_bubble_count <= r_bubble_count + 16'd1;
      end

      if (redirect_valid) begin
        r_state      <= ST_RUN;
        r_pc         <= redirect_target;
        r_if_is_jump <= 1'b0;
      end else begin
        case (r_state)
          ST_BOOT: begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_if_is_jump <= 1'b0;
          end
          default: begin
            if (stall) begin
              r_state <= ST_HOLD;
            end else begin
              r_state          <= ST_RUN;
              r_if_instruction <= imem_instruction;
              r_if_pc          <= r_pc;
              r_if_is_jump     <= w_is_jump;
              r_pc             <= w_next_pc;
            end
          end
        endcase
      end
    end
  end

  assign imem_address   = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instruction = r_if_instruction;
  assign if_pc          = r_if_pc;
  assign if_is_jump     = r_if_is_jump;
  assign bubble_count   = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit : vector table + scoreboard bench for fetch unit
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [29:0] tgt;
    logic        exp_valid;
    logic [29:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_jump;
    logic [29:0] exp_addr;
    logic [15:0] exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [29:0] redirect_target;
  logic [29:0] imem_address;
  logic [31:0] imem_instruction;
  logic        if_valid, if_is_jump;
  logic [31:0] if_instruction;
  logic [29:0] if_pc;
  logic [15:0] bubble_count;

  logic        reset2;
  logic [29:0] imem_address2;
  logic [31:0] imem_instruction2;
  logic        if_valid2, if_is_jump2;
  logic [31:0] if_instruction2;
  logic [29:0] if_pc2;
  logic [15:0] bubble_count2;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[15];
  vec_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [29:0] a);
    case (a)
      30'h0:   return 32'h00221820;
      30'h1:   return 32'h0485FFFF;
      30'h2:   return 32'h08000020;
      30'h20:  return 32'h00000000;
      default: return 32'h20000000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign imem_instruction  = rom(imem_address);
  assign imem_instruction2 = rom(imem_address2);

  instruction_fetch_unit #(.RESET_PC(30'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .if_valid         (if_valid),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_is_jump       (if_is_jump),
    .bubble_count     (bubble_count)
  );

  instruction_fetch_unit #(.RESET_PC(30'h3FFFFFFF)) dut_wrap (
    .clk              (clk),
    .reset            (reset2),
    .stall            (1'b0),
    .redirect_valid   (1'b0),
    .redirect_target  (30'h0),
    .imem_address     (imem_address2),
    .imem_instruction (imem_instruction2),
    .if_valid         (if_valid2),
    .if_instruction   (if_instruction2),
    .if_pc            (if_pc2),
    .if_is_jump       (if_is_jump2),
    .bubble_count     (bubble_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic stl, input logic rd,
                              input logic [29:0] tgt, input logic v, input logic [29:0] pc,
                              input logic [31:0] ins, input logic j,
                              input logic [29:0] addr, input logic [15:0] cnt);
    vec_t r;
    r.rst = rst; r.stall = stl; r.redir = rd; r.tgt = tgt;
    r.exp_valid = v; r.exp_pc = pc; r.exp_instr = ins; r.exp_jump = j;
    r.exp_addr = addr; r.exp_cnt = cnt;
    return r;
  endfunction

  initial begin
    vec_t e;
    //             rst  stl  rd   tgt      v    pc        instr         j    addr      cnt
    vecs[0]  = mk(1'b0,1'b0,1'b0,30'h0,  1'b0,30'h0,   32'h0,        1'b0,30'h0,   16'd1);
    vecs[1]  = mk(1'b0,1'b0,1'b0,30'h0,  1'b1,30'h0,   32'h00221820, 1'b0,30'h1,   16'd1);
    vecs[2]  = mk(1'b0,1'b0,1'b0,30'h0,  1'b1,30'h1,   32'h0485FFFF, 1'b0,30'h2,   16'd1);
    vecs[3]  = mk(1'b0,1'b1,1'b0,30'h0,  1'b1,30'h1,   32'h0485FFFF, 1'b0,30'h2,   16'd1);
    vecs[4]  = mk(1'b0,1'b1,1'b0,30'h0,  1'b1,30'h1,   32'h0485FFFF, 1'b0,30'h2,   16'd1);
    vecs[5]  = mk(1'b0,1'b1,1'b0,30'h0,  1'b1,30'h1,   32'h0485FFFF, 1'b0,30'h2,   16'd1);
    vecs[6]  = mk(1'b0,1'b0,1'b0,30'h0,  1'b1,30'h2,   32'h08000020, 1'b1,30'h20,  16'd1);
    vecs[7]  = mk(1'b0,1'b0,1'b0,30'h0,  1'b1,30'h20,  32'h00000000, 1'b0,30'h21,  16'd1);
    vecs[8]  = mk(1'b0,1'b1,1'b1,30'h100,1'b0,30'h0,   32'h0,        1'b0,30'h100, 16'd2);
    vecs[9]  = mk(1'b0,1'b0,1'b0,30'h0,  1'b1,30'h100, 32'h20000100, 1'b0,30'h101, 16'd2);
    vecs[10] = mk(1'b0,1'b0,1'b0,30'h0,  1'b1,30'h101, 32'h20000101, 1'b0,30'h102, 16'd2);
    vecs[11] = mk(1'b0,1'b1,1'b0,30'h0,  1'b1,30'h101, 32'h20000101, 1'b0,30'h102, 16'd2);
    vecs[12] = mk(1'b1,1'b1,1'b1,30'h55, 1'b0,30'h0,   32'h0,        1'b0,30'h0,   16'd0);
    vecs[13] = mk(1'b0,1'b1,1'b0,30'h0,  1'b0,30'h0,   32'h0,        1'b0,30'h0,   16'd1);
    vecs[14] = mk(1'b0,1'b0,1'b0,30'h0,  1'b1,30'h0,   32'h00221820, 1'b0,30'h1,   16'd1);

    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 30'h7;
    reset2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset if_valid",  {31'b0, if_valid}, 32'h0);
    check("reset if_instr",  if_instruction, 32'h0);
    check("reset if_pc",     {2'b0, if_pc}, 32'h0);
    check("reset if_jump",   {31'b0, if_is_jump}, 32'h0);
    check("reset imem_addr", {2'b0, imem_address}, 32'h0);
    check("reset bubbles",   {16'b0, bubble_count}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      reset = vecs[i].rst; stall = vecs[i].stall;
      redirect_valid = vecs[i].redir; redirect_target = vecs[i].tgt;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d if_valid", i),  {31'b0, if_valid}, {31'b0, e.exp_valid});
      check($sformatf("v%0d if_jump", i),   {31'b0, if_is_jump}, {31'b0, e.exp_jump});
      check($sformatf("v%0d imem_addr", i), {2'b0, imem_address}, {2'b0, e.exp_addr});
      check($sformatf("v%0d bubbles", i),   {16'b0, bubble_count}, {16'b0, e.exp_cnt});
      if (e.exp_valid || e.rst) begin
        check($sformatf("v%0d if_pc", i),    {2'b0, if_pc}, {2'b0, e.exp_pc});
        check($sformatf("v%0d if_instr", i), if_instruction, e.exp_instr);
      end
    end

    // PC wrap from the top of the 30-bit word space
    reset2 = 1'b0;
    @(posedge clk); #1;
    check("wrap boot valid", {31'b0, if_valid2}, 32'h0);
    check("wrap boot addr",  {2'b0, imem_address2}, 32'h3FFFFFFF);
    @(posedge clk); #1;
    check("wrap first valid", {31'b0, if_valid2}, 32'h1);
    check("wrap first pc",    {2'b0, if_pc2}, 32'h3FFFFFFF);
    check("wrap first instr", if_instruction2, 32'h2000FFFF);
    check("wrap addr",        {2'b0, imem_address2}, 32'h0);
    @(posedge clk); #1;
    check("wrap second pc",    {2'b0, if_pc2}, 32'h0);
    check("wrap second instr", if_instruction2, 32'h00221820);
    check("wrap bubbles",      {16'b0, bubble_count2}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 30'h0, word address fetched first after reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: stall  input  1  decode stage not ready; hold fetch output.
REQ-005 SHALL have port: redirect_valid  input  1  execute-resolved branch taken; flush and refetch.
REQ-006 SHALL have port: redirect_target  input  30  word address to refetch from.
REQ-007 SHALL have port: imem_address  output  30  word address to the combinational instruction ROM.
REQ-008 SHALL have port: imem_instruction  input  32  ROM data, valid in the same cycle as imem_address.
REQ-009 SHALL have port: if_valid  output  1  if_* outputs hold a real instruction.
REQ-010 SHALL have port: if_instruction  output  32  registered fetched instruction.
REQ-011 SHALL have port: if_pc  output  30  word address of if_instruction.
REQ-012 SHALL have port: if_is_jump  output  1  if_instruction opcode is 6'b000010.
REQ-013 SHALL have port: bubble_count  output  16  saturating count of cycles with if_valid=0 since reset.

Function
REQ-014 SHALL drive imem_address combinationally from internal pc register.
REQ-015 SHALL implement states BOOT, RUN, HOLD; BOOT after reset, BOOT->RUN next cycle unconditionally, RUN->HOLD on stall, HOLD->RUN when stall deasserts.
REQ-016 SHALL, in BOOT, keep if_valid=0 and pc=RESET_PC (one bubble).
REQ-017 SHALL, in RUN with stall=0 and redirect_valid=0, capture imem_instruction into if_instruction, pc into if_pc, set if_valid=1, and advance pc to next_pc.
REQ-018 SHALL compute next_pc = {pc_plus1[29:26], imem_instruction[25:0]} when imem_instruction[31:26]=6'b000010, else pc+1 (pc_plus1 = pc+1 mod 2^30).
REQ-019 SHALL treat all other opcodes, including REGIMM 6'b000001, as sequential (static not-taken); no delay slot.
REQ-020 SHALL, while stall=1 and redirect_valid=0, hold pc and all if_* outputs unchanged.
REQ-021 SHALL give redirect_valid priority over stall and jump: next edge pc<=redirect_target, if_valid<=0, state<=RUN; fetch from target begins following cycle.
REQ-022 SHALL wrap pc from 30'h3FFFFFFF to 30'h0 without error.
REQ-023 SHALL set if_is_jump in the same edge if_instruction is loaded; 0 whenever if_valid=0.
REQ-024 SHALL increment bubble_count on every non-reset edge where if_valid becomes/remains 0, saturating at 16'hFFFF.
REQ-025 SHALL keep latency ROM-to-if_instruction exactly one clock edge.

Reset
REQ-026 SHALL, on any edge with reset=1, regardless of state, stall or redirect: pc<=RESET_PC, state<=BOOT, if_valid<=0, if_instruction<=0, if_pc<=0, if_is_jump<=0, bubble_count<=0.
REQ-027 SHALL give reset priority over redirect_valid and stall; a reset mid-stall discards the held instruction.

Structure
REQ-028 SHALL place opcode constants (OP_RTYPE 6'b000000, OP_REGIMM 6'b000001, OP_J 6'b000010) and the state encoding in the shared MIPS definitions package.
REQ-029 SHALL implement the jump target/next_pc computation as sub-module fetch_next_pc (combinational).
REQ-030 SHALL contain no memory; it connects directly to the existing instruction ROM.

Verification
REQ-031 SHALL test reset release with ROM program {0: 0x00221820, 1: 0x0485FFFF, 2: 0x08000020} -> if_valid=0 one cycle, then if_pc=0,1,2 with matching instructions on consecutive cycles.
REQ-032 SHALL test jump at address 2 -> if_is_jump=1 with if_pc=2, next if_pc=0x20, instruction 0, no bubble inserted.
REQ-033 SHALL test stall held 3 cycles while if_pc=1 -> if_pc=1 and if_instruction=0x0485FFFF stable, imem_address=2 stable, resume with if_pc=2.
REQ-034 SHALL test redirect_valid=1, target=0x100 asserted together with stall=1 -> next cycle if_valid=0, imem_address=0x100, then if_pc=0x100.
REQ-035 SHALL test RESET_PC=30'h3FFFFFFF -> if_pc sequence 0x3FFFFFFF then 0x0.
REQ-036 SHALL test reset asserted during HOLD -> all outputs zero next edge, bubble_count=0, BOOT bubble repeats.
